ysyx_25060170_lsu: RTL and testbench
====================================

YSYX_25060170_LSU -- requirements
Module: ysyx_25060170_lsu

Interface
REQ-001 SHALL have parameter: none; all widths fixed at 32-bit data/address, 4-bit byte mask.
REQ-002 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  in  1  EXU result valid; in_ready  out  1  LSU can accept.
REQ-005 SHALL have ports: mem_ren  in  1  load; mem_wen  in  1  store; mem_funct3  in  3  access size/sign.
REQ-006 SHALL have ports: addr  in  32  effective address (EXU ALU result); wdata  in  32  store data (rs2).
REQ-007 SHALL have ports: req_valid  out  1; req_ready  in  1; req_wen  out  1; req_addr  out  32; req_wdata  out  32; req_wmask  out  4.
REQ-008 SHALL have ports: rsp_valid  in  1  memory read data or write acknowledgement; rsp_rdata  in  32.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_rdata  out  32  extended load data to WBU; out_err  out  1  misaligned access.

Function
REQ-010 SHALL implement FSM with states IDLE, REQ, WAIT, RESP.
REQ-011 SHALL assert in_ready only in IDLE; accept on in_valid & in_ready, latching addr, wdata, funct3, ren, wen.
REQ-012 SHALL give a store (mem_wen=1) priority when mem_ren and mem_wen are both 1; ren is then ignored.
REQ-013 SHALL, for an accepted op with ren=wen=0, go IDLE->RESP, with out_valid on the next cycle and out_rdata=0.
REQ-014 SHALL, for load/store, go IDLE->REQ; assert req_valid in REQ and hold req_addr/wdata/wmask/wen stable until req_ready.
REQ-015 SHALL go REQ->WAIT on req_valid & req_ready; in WAIT, ignore req_ready and go WAIT->RESP on rsp_valid.
REQ-016 SHALL ignore rsp_valid in any state other than WAIT.
REQ-017 SHALL capture rsp_rdata in the WAIT->RESP cycle; a store takes the same path with out_rdata=0.
REQ-018 SHALL hold out_valid=1 in RESP with stable outputs until out_ready; RESP->IDLE on out_valid & out_ready; no back-to-back accept in the same cycle.
REQ-019 SHALL drive req_addr = {addr[31:2],2'b00}.
REQ-020 SHALL decode funct3: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; 011/110/111 treated as word.
REQ-021 SHALL, for stores, replicate data across lanes (SB: {4{wdata[7:0]}}, SH: {2{wdata[15:0]}}, SW: wdata).
REQ-022 SHALL set wmask: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; req_wmask=0 for loads.
REQ-023 SHALL select the load byte lane by addr[1:0] and the half lane by addr[1], then sign- or zero-extend to 32 bits.
REQ-024 SHALL total minimum latency, load/store with req_ready=1 and rsp_valid the cycle after: accept at cycle 0, out_valid at cycle 3.

Reset
REQ-025 SHALL on rst, immediately and asynchronously: state=IDLE; req_valid=0, out_valid=0, out_err=0, out_rdata=0, all latched fields=0; in_ready=1 once rst deasserts.
REQ-026 SHALL abandon any in-flight request on rst mid-operation; a later rsp_valid is ignored per REQ-016.

Configuration
REQ-027 SHALL use macro YSYX_25060170_LSU_MISALIGN_CHECK_EN.
REQ-028 SHALL, when the macro is defined: for a misaligned half (addr[0]=1) or word (addr[1:0]!=0) access, go IDLE->RESP without a bus request, with out_err=1 and out_rdata=0.
REQ-029 SHALL, when the macro is undefined: perform no check; out_err is tied 0, and low address bits select lanes per REQ-022/023 (word ignores addr[1:0]).

Verification
REQ-030 SHALL cover LB: addr=0x80000003, rsp_rdata=0x80FF1234 -> out_rdata=0xFFFFFF80; LBU -> 0x00000080.
REQ-031 SHALL cover SH: addr=0x80000002, wdata=0x0000BEEF -> req_wdata=0xBEEFBEEF, req_wmask=4'b1100, req_addr=0x80000000.
REQ-032 SHALL cover req_ready held low 5 cycles: req_valid stays 1 and the address stays stable; out_valid appears 1 cycle after rsp_valid; out_ready low 3 cycles keeps out_rdata stable.
REQ-033 SHALL cover LW at addr=0x80000006: with the macro, out_err=1 and no req_valid; without the macro, req_addr=0x80000004 and out_err=0.
REQ-034 SHALL cover rst pulsed in WAIT: req_valid/out_valid drop without a clock; a later stray rsp_valid produces no out_valid.
REQ-035 SHALL cover ren=wen=0: out_valid the cycle after accept, out_rdata=0, no bus activity.

Source files
------------

// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit: EXU op -> bus request -> response -> WBU, with lane steering.
// Optional misalignment trap when YSYX_25060170_LSU_MISALIGN_CHECK_EN is defined.
module ysyx_25060170_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_wen,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wmask,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        wen_q, wen_d;
    logic        ren_q, ren_d;
    logic        misalign;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;

`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
    logic err_q, err_d;
    logic in_half, in_word;

    assign in_half  = (mem_funct3[1:0] == 2'b01);
    assign in_word  = mem_funct3[1];
    assign misalign = (mem_ren | mem_wen) &
                      ((in_half & addr[0]) | (in_word & (addr[1:0] != 2'b00)));
    assign out_err  = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && in_valid) begin
            err_d = misalign;
        end
    end
`else
    assign misalign = 1'b0;
    assign out_err  = 1'b0;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign req_valid = (state_q == S_REQ);
    assign out_valid = (state_q == S_RESP);
    assign out_rdata = rdata_q;
    assign req_wen   = wen_q;
    assign req_addr  = {addr_q[31:2], 2'b00};

    // funct3[1:0]: 00 byte, 01 half, 1x word
    always_comb begin
        unique case (funct3_q[1:0])
            2'b00: begin
                req_wdata = {4{wdata_q[7:0]}};
                req_wmask = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                req_wdata = {2{wdata_q[15:0]}};
                req_wmask = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: begin
                req_wdata = wdata_q;
                req_wmask = 4'b1111;
            end
        endcase
        if (!wen_q) begin
            req_wmask = 4'b0000;
        end
    end

    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   ld_b = rsp_rdata[7:0];
            2'b01:   ld_b = rsp_rdata[15:8];
            2'b10:   ld_b = rsp_rdata[23:16];
            default: ld_b = rsp_rdata[31:24];
        endcase
        ld_h = addr_q[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
        unique case (funct3_q)
            3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b100:  ld_ext = {24'd0, ld_b};
            3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b101:  ld_ext = {16'd0, ld_h};
            default: ld_ext = rsp_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        funct3_d = funct3_q;
        wen_d    = wen_q;
        ren_d    = ren_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    addr_d   = addr;
                    wdata_d  = wdata;
                    funct3_d = mem_funct3;
                    wen_d    = mem_wen;
                    ren_d    = mem_ren & ~mem_wen;
                    rdata_d  = 32'd0;
                    if ((mem_ren | mem_wen) && !misalign) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_REQ: begin
                if (req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    rdata_d = ren_q ? ld_ext : 32'd0;
                    state_d = S_RESP;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            wen_q    <= wen_d;
            ren_q    <= ren_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Directed bench for ysyx_25060170_lsu: lane steering, handshakes, stalls, reset.
// Honours YSYX_25060170_LSU_MISALIGN_CHECK_EN for the misaligned-word case.
module tb_ysyx_25060170_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        mem_ren, mem_wen;
    logic [2:0]  mem_funct3;
    logic [31:0] addr, wdata;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_25060170_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_funct3 (mem_funct3),
        .addr       (addr),
        .wdata      (wdata),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rdata  (out_rdata),
        .out_err    (out_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept one op; returns at the negedge after the accepting edge.
    task automatic issue(input string t, input logic r, input logic w,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        check({t, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        mem_ren    = r;
        mem_wen    = w;
        mem_funct3 = f3;
        addr       = a;
        wdata      = wd;
        @(negedge clk);
        in_valid   = 1'b0;
        addr       = 32'hFFFF_FFFF;
        wdata      = 32'h0BAD_0BAD;
    endtask

    task automatic run_op(input string t, input logic r, input logic w,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input logic [31:0] e_addr, input logic [3:0] e_mask,
                          input logic [31:0] e_wd, input logic [31:0] e_rd,
                          input int req_stall, input int out_stall);
        issue(t, r, w, f3, a, wd);
        for (int i = 0; i < req_stall; i++) begin
            check({t, " stall req_valid"}, {31'd0, req_valid}, 32'd1);
            check({t, " stall req_addr"}, req_addr, e_addr);
            rsp_valid = 1'b1;
            rsp_rdata = 32'h1111_1111;
            @(negedge clk);
        end
        rsp_valid = 1'b0;
        check({t, " req_valid"}, {31'd0, req_valid}, 32'd1);
        check({t, " req_addr"}, req_addr, e_addr);
        check({t, " req_wen"}, {31'd0, req_wen}, {31'd0, w});
        check({t, " req_wmask"}, {28'd0, req_wmask}, {28'd0, e_mask});
        if (w) check({t, " req_wdata"}, req_wdata, e_wd);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check({t, " wait req_valid"}, {31'd0, req_valid}, 32'd0);
        check({t, " wait out_valid"}, {31'd0, out_valid}, 32'd0);
        rsp_valid = 1'b1;
        rsp_rdata = rd;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_rdata = 32'h5A5A_5A5A;
        check({t, " out_valid"}, {31'd0, out_valid}, 32'd1);
        check({t, " out_rdata"}, out_rdata, e_rd);
        check({t, " out_err"}, {31'd0, out_err}, 32'd0);
        for (int i = 0; i < out_stall; i++) begin
            @(negedge clk);
            check({t, " hold out_valid"}, {31'd0, out_valid}, 32'd1);
            check({t, " hold out_rdata"}, out_rdata, e_rd);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({t, " done out_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic rst_pulse();
        #2 rst = 1'b1;
        #1;
        check("rst req_valid", {31'd0, req_valid}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_rdata", out_rdata, 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; req_ready = 1'b0; rsp_valid = 1'b0;
        rsp_rdata = 32'd0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset req_valid", {31'd0, req_valid}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_err", {31'd0, out_err}, 32'd0);
        check("reset out_rdata", out_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("LB",  1, 0, 3'b000, 32'h8000_0003, 0, 32'h80FF_1234,
               32'h8000_0000, 4'b0000, 0, 32'hFFFF_FF80, 0, 0);
        run_op("LBU", 1, 0, 3'b100, 32'h8000_0003, 0, 32'h80FF_1234,
               32'h8000_0000, 4'b0000, 0, 32'h0000_0080, 0, 0);
        run_op("LB1", 1, 0, 3'b000, 32'h8000_0001, 0, 32'h80FF_1234,
               32'h8000_0000, 4'b0000, 0, 32'h0000_0012, 0, 0);
        run_op("LH",  1, 0, 3'b001, 32'h8000_0002, 0, 32'h80FF_1234,
               32'h8000_0000, 4'b0000, 0, 32'hFFFF_80FF, 0, 0);
        run_op("LHU", 1, 0, 3'b101, 32'h8000_0002, 0, 32'h80FF_1234,
               32'h8000_0000, 4'b0000, 0, 32'h0000_80FF, 0, 0);
        run_op("LH0", 1, 0, 3'b001, 32'h8000_0000, 0, 32'h80FF_9234,
               32'h8000_0000, 4'b0000, 0, 32'hFFFF_9234, 0, 0);
        run_op("SH",  0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h1234_5678,
               32'h8000_0000, 4'b1100, 32'hBEEF_BEEF, 0, 0, 0);
        run_op("SB",  0, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h1234_5678,
               32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 0, 0, 0);
        run_op("SW",  0, 1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 32'h1234_5678,
               32'h8000_0010, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0);
        run_op("RW",  1, 1, 3'b010, 32'h8000_0014, 32'h0102_0304, 32'h1234_5678,
               32'h8000_0014, 4'b1111, 32'h0102_0304, 0, 0, 0);
        run_op("LW6", 1, 0, 3'b110, 32'h8000_0008, 0, 32'hCAFE_F00D,
               32'h8000_0008, 4'b0000, 0, 32'hCAFE_F00D, 0, 0);
        run_op("LWST", 1, 0, 3'b010, 32'h8000_0020, 0, 32'h7654_3210,
               32'h8000_0020, 4'b0000, 0, 32'h7654_3210, 5, 3);

`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
        issue("MIS", 1, 0, 3'b010, 32'h8000_0006, 0);
        check("MIS req_valid", {31'd0, req_valid}, 32'd0);
        check("MIS out_valid", {31'd0, out_valid}, 32'd1);
        check("MIS out_err", {31'd0, out_err}, 32'd1);
        check("MIS out_rdata", out_rdata, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("MIS done", {31'd0, out_valid}, 32'd0);
`else
        run_op("MIS", 1, 0, 3'b010, 32'h8000_0006, 0, 32'hA1B2_C3D4,
               32'h8000_0004, 4'b0000, 0, 32'hA1B2_C3D4, 0, 0);
`endif

        issue("NOP", 0, 0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        check("NOP req_valid", {31'd0, req_valid}, 32'd0);
        check("NOP out_valid", {31'd0, out_valid}, 32'd1);
        check("NOP out_rdata", out_rdata, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("NOP done", {31'd0, out_valid}, 32'd0);

        issue("RREQ", 1, 0, 3'b010, 32'h8000_0030, 0);
        check("RREQ req_valid", {31'd0, req_valid}, 32'd1);
        rst_pulse();
        @(negedge clk);
        check("RREQ in_ready", {31'd0, in_ready}, 32'd1);

        issue("RWAIT", 1, 0, 3'b010, 32'h8000_0034, 0);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rst_pulse();
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_rdata = 32'hDEAD_DEAD;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("RWAIT stray out_valid", {31'd0, out_valid}, 32'd0);
        check("RWAIT in_ready", {31'd0, in_ready}, 32'd1);

        issue("RRESP", 0, 0, 3'b000, 32'h0, 0);
        check("RRESP out_valid", {31'd0, out_valid}, 32'd1);
        rst_pulse();
        @(negedge clk);
        check("RRESP in_ready", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
